mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch requester (IF stage) and the data requester (ME stage) of the 5-stage pipeline.
- Sequences each access as a req/ack transaction with variable memory latency.
- Returns read data and a one-cycle ready pulse to the winning requester.
- Drives per-stage stall requests that the control unit folds into its stall vector.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/arb_grant_sel.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the unified-memory port arbiter:
//   - WCONVW    : width of the memory write-type/size code
//   - REQ_IF/ME : requester identifiers used by the grant selector and FSM
//   - arb_state_e : 3-bit FSM state encoding
package mem_port_arbiter_pkg;

  localparam int WCONVW = 3;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_ME = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BUSY_IF = 3'd1,
    BUSY_ME = 3'd2,
    DONE_IF = 3'd3,
    DONE_ME = 3'd4
  } arb_state_e;

endpackage

// File: rtl/arb_grant_sel.sv
// arb_grant_sel
// Combinational grant policy for the memory port arbiter.
// Build option: ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, data (ME) over fetch (IF); no last_grant port
//   defined   : on a tie the requester not served last wins
// Ports:
//   last_grant  in  requester served last (only with ARB_ROUND_ROBIN_EN)
//   if_req      in  fetch request
//   me_req      in  data request
//   grant_id    out winning requester (REQ_IF / REQ_ME)
//   grant_valid out at least one request is pending
module arb_grant_sel
  import mem_port_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_grant,
`endif
  input  logic if_req,
  input  logic me_req,
  output logic grant_id,
  output logic grant_valid
);

  // Pick the winner among the pending requests.
  always_comb begin
    grant_valid = if_req | me_req;
    grant_id    = REQ_ME;
    if (if_req && me_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_id = (last_grant == REQ_ME) ? REQ_IF : REQ_ME;
`else
      grant_id = REQ_ME;
`endif
    end else if (me_req) begin
      grant_id = REQ_ME;
    end else if (if_req) begin
      grant_id = REQ_IF;
    end else begin
      grant_id = REQ_ME;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the IF (fetch) and ME (data)
// requesters. Each access is a req/ack transaction of variable latency;
// the winner gets its read data plus a one-cycle ready pulse.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// (otherwise data always beats fetch).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr           fetch request (level, held until if_ready)
//   if_rdata/if_ready        fetched word and completion pulse
//   me_req/me_wena/me_addr/me_wdata/me_wtype  data request
//   me_rdata/me_ready        load data and completion pulse
//   mem_req..mem_wtype       memory request bus (held until mem_ack)
//   mem_ack/mem_rdata        memory completion and read data
//   stall_if/stall_me        per-stage hold requests (combinational)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WT_W   = WCONVW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              me_req,
  input  logic              me_wena,
  input  logic [ADDR_W-1:0] me_addr,
  input  logic [DATA_W-1:0] me_wdata,
  input  logic [WT_W-1:0]   me_wtype,
  output logic [DATA_W-1:0] me_rdata,
  output logic              me_ready,
  output logic              mem_req,
  output logic              mem_wena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [WT_W-1:0]   mem_wtype,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_me
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wena_q, mem_wena_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [WT_W-1:0]   mem_wtype_q, mem_wtype_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] me_rdata_q, me_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              me_ready_q, me_ready_d;
  logic              grant_id;
  logic              grant_valid;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;
`endif

  arb_grant_sel u_grant_sel (
`ifdef ARB_ROUND_ROBIN_EN
    .last_grant  (last_grant_q),
`endif
    .if_req      (if_req),
    .me_req      (me_req),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  // Next-state and register-update logic for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_wena_d  = mem_wena_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wtype_d = mem_wtype_q;
    if_rdata_d  = if_rdata_q;
    me_rdata_d  = me_rdata_q;
    if_ready_d  = if_ready_q;
    me_ready_d  = me_ready_q;
    case (state_q)
      IDLE: begin
        if (grant_valid && (grant_id == REQ_ME)) begin
          mem_req_d   = 1'b1;
          mem_wena_d  = me_wena;
          mem_addr_d  = me_addr;
          mem_wdata_d = me_wdata;
          mem_wtype_d = me_wtype;
          state_d     = BUSY_ME;
        end else if (grant_valid) begin
          mem_req_d   = 1'b1;
          mem_wena_d  = 1'b0;
          mem_addr_d  = if_addr;
          mem_wtype_d = '0;
          state_d     = BUSY_IF;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_IF: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
          state_d    = DONE_IF;
        end else begin
          state_d = BUSY_IF;
        end
      end
      BUSY_ME: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          // Stores return nothing; keep the last load value visible.
          if (!mem_wena_q) begin
            me_rdata_d = mem_rdata;
          end else begin
            me_rdata_d = me_rdata_q;
          end
          me_ready_d = 1'b1;
          state_d    = DONE_ME;
        end else begin
          state_d = BUSY_ME;
        end
      end
      // Requests are deliberately not sampled in DONE so a held req
      // cannot issue twice for one transaction.
      DONE_IF: begin
        if_ready_d = 1'b0;
        state_d    = IDLE;
      end
      DONE_ME: begin
        me_ready_d = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        mem_req_d  = 1'b0;
        if_ready_d = 1'b0;
        me_ready_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_wena_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wtype_q <= '0;
      if_rdata_q  <= '0;
      me_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      me_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_wena_q  <= mem_wena_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wtype_q <= mem_wtype_d;
      if_rdata_q  <= if_rdata_d;
      me_rdata_q  <= me_rdata_d;
      if_ready_q  <= if_ready_d;
      me_ready_q  <= me_ready_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember which requester was granted at each issue.
  always_comb begin
    if ((state_q == IDLE) && grant_valid) begin
      last_grant_d = grant_id;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant flag register; resets to data so fetch wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= REQ_ME;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign mem_req   = mem_req_q;
  assign mem_wena  = mem_wena_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wtype = mem_wtype_q;
  assign if_rdata  = if_rdata_q;
  assign me_rdata  = me_rdata_q;
  assign if_ready  = if_ready_q;
  assign me_ready  = me_ready_q;

  // The ready pulse releases the stall in the same cycle it is seen.
  assign stall_if = if_req & ~if_ready_q;
  assign stall_me = me_req & ~me_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: a table of single-requester
// transactions followed by hand-written tie, reset and held-request sequences.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        me_req;
  logic        me_wena;
  logic [31:0] me_addr;
  logic [31:0] me_wdata;
  logic [2:0]  me_wtype;
  logic [31:0] me_rdata;
  logic        me_ready;
  logic        mem_req;
  logic        mem_wena;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_wtype;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_me;

  int tests_run;
  int tests_failed;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .me_req    (me_req),
    .me_wena   (me_wena),
    .me_addr   (me_addr),
    .me_wdata  (me_wdata),
    .me_wtype  (me_wtype),
    .me_rdata  (me_rdata),
    .me_ready  (me_ready),
    .mem_req   (mem_req),
    .mem_wena  (mem_wena),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wtype (mem_wtype),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_me  (stall_me)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_me;
    logic        wena;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  wtype;
    int          waits;
    logic [31:0] rd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one already-pending request starting from an IDLE cycle.
  task automatic serve(input logic is_me, input logic [31:0] exp_addr,
                       input logic exp_wena, input logic [31:0] exp_wdata,
                       input logic [2:0] exp_wtype, input int waits,
                       input logic [31:0] rd, input logic [31:0] exp_rdata);
    #1;
    chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
    chk("stall_before_grant", {31'd0, (is_me ? stall_me : stall_if)}, 32'd1);
    tick();
    for (int w = 0; w <= waits; w++) begin
      chk("busy_mem_req", {31'd0, mem_req}, 32'd1);
      chk("busy_mem_addr", mem_addr, exp_addr);
      chk("busy_mem_wena", {31'd0, mem_wena}, {31'd0, exp_wena});
      chk("busy_mem_wtype", {29'd0, mem_wtype}, {29'd0, exp_wtype});
      if (exp_wena) chk("busy_mem_wdata", mem_wdata, exp_wdata);
      chk("busy_ready_low", {31'd0, (is_me ? me_ready : if_ready)}, 32'd0);
      chk("busy_stall", {31'd0, (is_me ? stall_me : stall_if)}, 32'd1);
      if (w == waits) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
    end
    chk("done_ready", {31'd0, (is_me ? me_ready : if_ready)}, 32'd1);
    chk("done_rdata", (is_me ? me_rdata : if_rdata), exp_rdata);
    chk("done_stall_low", {31'd0, (is_me ? stall_me : stall_if)}, 32'd0);
    chk("done_mem_req_low", {31'd0, mem_req}, 32'd0);
    if (is_me) me_req = 1'b0;
    else if_req = 1'b0;
    tick();
    chk("after_ready_low", {31'd0, (is_me ? me_ready : if_ready)}, 32'd0);
    chk("after_mem_req_low", {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    logic first_me;
    int   issues;
    logic prev_req;

    tests_run    = 0;
    tests_failed = 0;

    //          is_me wena addr          wdata         wtype waits rd            exp_rdata
    vecs[0] = '{1'b0, 1'b0, 32'h00400000, 32'h00000000, 3'd0, 2, 32'h20080005, 32'h20080005};
    vecs[1] = '{1'b1, 1'b1, 32'h10010004, 32'hDEADBEEF, 3'd2, 0, 32'h12345678, 32'h00000000};
    vecs[2] = '{1'b1, 1'b0, 32'h10010008, 32'h00000000, 3'd1, 1, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[3] = '{1'b1, 1'b1, 32'h1001000C, 32'h0BADF00D, 3'd4, 3, 32'hFFFFFFFF, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b0, 32'h00400004, 32'h00000000, 3'd0, 0, 32'h8C090000, 32'h8C090000};
    vecs[5] = '{1'b1, 1'b0, 32'h10010010, 32'h00000000, 3'd2, 0, 32'h00000042, 32'h00000042};

    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; me_req = 1'b0; me_wena = 1'b0;
    me_addr = 32'h0; me_wdata = 32'h0; me_wtype = 3'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_wena", {31'd0, mem_wena}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wtype", {29'd0, mem_wtype}, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_me_ready", {31'd0, me_ready}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_me_rdata", me_rdata, 32'd0);
    chk("rst_stalls", {30'd0, stall_if, stall_me}, 32'd0);

    // Table of single-requester transactions.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_me) begin
        me_req = 1'b1; me_wena = vecs[i].wena; me_addr = vecs[i].addr;
        me_wdata = vecs[i].wdata; me_wtype = vecs[i].wtype;
        serve(1'b1, vecs[i].addr, vecs[i].wena, vecs[i].wdata, vecs[i].wtype,
              vecs[i].waits, vecs[i].rd, vecs[i].exp_rdata);
        chk("vec_if_ready_quiet", {31'd0, if_ready}, 32'd0);
      end else begin
        if_req = 1'b1; if_addr = vecs[i].addr;
        serve(1'b0, vecs[i].addr, 1'b0, 32'h0, 3'd0,
              vecs[i].waits, vecs[i].rd, vecs[i].exp_rdata);
        chk("vec_me_ready_quiet", {31'd0, me_ready}, 32'd0);
      end
    end

    // Simultaneous requests after a data grant.
`ifdef ARB_ROUND_ROBIN_EN
    first_me = 1'b0;
`else
    first_me = 1'b1;
`endif
    me_wena = 1'b0; me_addr = 32'h10020000; me_wtype = 3'd2; if_addr = 32'h00400100;
    if_req = 1'b1; me_req = 1'b1;
    if (first_me) begin
      serve(1'b1, 32'h10020000, 1'b0, 32'h0, 3'd2, 0, 32'hAAAA5555, 32'hAAAA5555);
      chk("tie_if_still_pending", {31'd0, stall_if}, 32'd1);
      serve(1'b0, 32'h00400100, 1'b0, 32'h0, 3'd0, 1, 32'h5555AAAA, 32'h5555AAAA);
    end else begin
      serve(1'b0, 32'h00400100, 1'b0, 32'h0, 3'd0, 1, 32'h5555AAAA, 32'h5555AAAA);
      chk("tie_me_still_pending", {31'd0, stall_me}, 32'd1);
      serve(1'b1, 32'h10020000, 1'b0, 32'h0, 3'd2, 0, 32'hAAAA5555, 32'hAAAA5555);
    end
    chk("tie_if_rdata_hold", if_rdata, 32'h5555AAAA);

    // Reset during BUSY_ME, then a stray ack.
    me_req = 1'b1; me_wena = 1'b0; me_addr = 32'h10030000;
    tick();
    chk("rstmid_busy", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rstmid_me_ready", {31'd0, me_ready}, 32'd0);
    me_req = 1'b0;
    tick();
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    chk("stray_ack_ready", {30'd0, if_ready, me_ready}, 32'd0);
    chk("stray_ack_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("stray_ack_ready2", {30'd0, if_ready, me_ready}, 32'd0);
    chk("stray_ack_rdata", me_rdata, 32'd0);

    // Request held high through DONE issues once per IDLE sample.
    me_req = 1'b1; me_wena = 1'b0; me_addr = 32'h10040000;
    issues = 0; prev_req = 1'b0;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (mem_req && !prev_req) issues++;
      prev_req = mem_req;
      if (c == 0) begin
        mem_ack = 1'b1; mem_rdata = 32'h00000011;
      end else begin
        mem_ack = 1'b0; mem_rdata = 32'h0;
      end
      if (c == 1) chk("held_done_ready", {31'd0, me_ready}, 32'd1);
      if (c == 2) chk("held_idle_no_req", {31'd0, mem_req}, 32'd0);
      if (c == 3) chk("held_reissue", {31'd0, mem_req}, 32'd1);
    end
    chk("held_issue_count", issues, 32'd2);
    me_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
